// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Holds the opcode encodings, the FSM state encoding and an opcode legality helper.
package serial_alu_ctrl_pkg;

    // Opcode encodings; op[2] inverts operand b and seeds the carry for SUB/SLT
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for the five supported opcodes
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bus of the bit-serial ALU sequencer.
// Request: in_valid/in_ready handshake carrying in_a, in_b, in_op.
// Response: out_valid/out_ready handshake carrying out_result, out_cout,
// out_zero, out_err and, with SERIAL_ALU_OVF_EN defined, out_ovf.
// Modports: master = requester/consumer side, slave = the ALU sequencer.
interface serial_alu_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_zero;
    logic             out_err;
`ifdef SERIAL_ALU_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_zero, out_err, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_zero, out_err, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_cout, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_cout, out_zero, out_err
    );
`endif
endinterface

// File: rtl/serial_alu_ctrl_bit_slice.sv
// One-bit ALU slice (combinational) used by the serial sequencer.
// Ports: a_i, b_i, carry_i - operand bits and incoming carry
//        op_i                - opcode, op_i[2] inverts b
//        bit_o               - per-opcode bit result (0 for SLT and illegal ops)
//        sum_o, carry_next_o - full-adder sum and carry out
module serial_bit_slice
    import serial_alu_ctrl_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carry_i,
    input  logic [2:0] op_i,
    output logic       bit_o,
    output logic       sum_o,
    output logic       carry_next_o
);

    logic bcomp;

    assign bcomp        = b_i ^ op_i[2];
    assign sum_o        = a_i ^ bcomp ^ carry_i;
    assign carry_next_o = (a_i & bcomp) | (a_i & carry_i) | (bcomp & carry_i);

    // Bit result select; SLT builds its result from the MSB sum instead
    always_comb begin
        bit_o = 1'b0;
        case (op_i)
            OP_AND:         bit_o = a_i & bcomp;
            OP_OR:          bit_o = a_i | bcomp;
            OP_ADD, OP_SUB: bit_o = sum_o;
            default:        bit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit AND/OR/ADD/SUB/SLT LSB-first,
// one bit per clock, through a single serial_bit_slice.
// Ports: clk   - rising-edge clock
//        reset - asynchronous active-high reset
//        bus   - serial_alu_ctrl_if.slave request/response handshakes
// Optional feature: SERIAL_ALU_OVF_EN adds the signed-overflow flag out_ovf.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    serial_alu_ctrl_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic               out_cout_q, out_cout_d;
    logic               out_zero_q, out_zero_d;
    logic               out_err_q, out_err_d;
`ifdef SERIAL_ALU_OVF_EN
    logic               out_ovf_q, out_ovf_d;
`endif

    logic               slice_bit;
    logic               slice_sum;
    logic               slice_carry;
    logic [WIDTH-1:0]   shifted_res;
    logic [WIDTH-1:0]   final_res;
    logic               is_arith;

    serial_bit_slice u_slice (
        .a_i          (a_q[0]),
        .b_i          (b_q[0]),
        .carry_i      (carry_q),
        .op_i         (op_q),
        .bit_o        (slice_bit),
        .sum_o        (slice_sum),
        .carry_next_o (slice_carry)
    );

    // Result accumulates from the MSB side so bit 0 ends up in place after WIDTH shifts
    assign shifted_res = (res_q >> 1) | (WIDTH'(slice_bit) << (WIDTH - 1));
    assign is_arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);

    // Result as it stands after the MSB cycle
    always_comb begin
        final_res = shifted_res;
        if (!op_is_legal(op_q)) begin
            final_res = '0;
        end else if (op_q == OP_SLT) begin
            final_res = WIDTH'(slice_sum);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            res_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_cout_q   <= 1'b0;
            out_zero_q   <= 1'b0;
            out_err_q    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            out_ovf_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            res_q        <= res_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_cout_q   <= out_cout_d;
            out_zero_q   <= out_zero_d;
            out_err_q    <= out_err_d;
`ifdef SERIAL_ALU_OVF_EN
            out_ovf_q    <= out_ovf_d;
`endif
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        res_d        = res_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_cout_d   = out_cout_q;
        out_zero_d   = out_zero_q;
        out_err_d    = out_err_q;
`ifdef SERIAL_ALU_OVF_EN
        out_ovf_d    = out_ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    op_d    = bus.in_op;
                    carry_d = bus.in_op[2];
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = slice_carry;
                res_d   = shifted_res;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d      = ST_DONE;
                    out_valid_d  = 1'b1;
                    out_result_d = final_res;
                    out_zero_d   = (final_res == '0);
                    out_err_d    = !op_is_legal(op_q);
                    out_cout_d   = is_arith ? slice_carry : 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                    // carry_q is the carry into the MSB on this cycle
                    out_ovf_d    = ((op_q == OP_ADD) || (op_q == OP_SUB)) ?
                                   (carry_q ^ slice_carry) : 1'b0;
`endif
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_cout   = out_cout_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_err    = out_err_q;
`ifdef SERIAL_ALU_OVF_EN
    assign bus.out_ovf    = out_ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl (WIDTH=32): directed vector table,
// hand-written backpressure / mid-run reset sequences, and random operations
// checked against an arithmetic reference model.
module tb_serial_alu_ctrl;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        zero;
        logic        err;
        logic        ovf;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        resp_t       exp;
        int          hold;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_alu_ctrl_if #(.WIDTH(W)) bus ();

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, no bit iteration
    function automatic resp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        resp_t       r;
        logic [32:0] s;
        r = '0;
        case (op)
            3'b000: r.res = a & b;
            3'b001: r.res = a | b;
            3'b010: begin
                s      = {1'b0, a} + {1'b0, b};
                r.res  = s[31:0];
                r.cout = s[32];
                r.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
            end
            3'b110: begin
                s      = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.res  = s[31:0];
                r.cout = s[32];
                r.ovf  = (a[31] != b[31]) && (s[31] != a[31]);
            end
            3'b111: begin
                s      = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.res  = {31'd0, s[31]};
                r.cout = s[32];
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"},  32'(bus.out_valid), 32'd0);
        check({tag, "_out_result"}, bus.out_result, 32'd0);
        check({tag, "_flags"},      {28'd0, bus.out_cout, bus.out_zero, bus.out_err, 1'b0}, 32'd0);
`ifdef SERIAL_ALU_OVF_EN
        check({tag, "_out_ovf"},    32'(bus.out_ovf), 32'd0);
`endif
    endtask

    // Present a request and return just after its accepting edge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int waited;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_op    = 3'($urandom_range(0, 7));
    endtask

    // Wait for the response, check it and latency, apply backpressure, handshake
    task automatic finish_op(input string name, input resp_t exp, input int hold);
        int    lat;
        resp_t snap;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(W));
        check({name, "_result"},  bus.out_result, exp.res);
        check({name, "_cout"},    32'(bus.out_cout), 32'(exp.cout));
        check({name, "_zero"},    32'(bus.out_zero), 32'(exp.zero));
        check({name, "_err"},     32'(bus.out_err), 32'(exp.err));
`ifdef SERIAL_ALU_OVF_EN
        check({name, "_ovf"},     32'(bus.out_ovf), 32'(exp.ovf));
        snap = {bus.out_result, bus.out_cout, bus.out_zero, bus.out_err, bus.out_ovf};
`else
        snap = {bus.out_result, bus.out_cout, bus.out_zero, bus.out_err, 1'b0};
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
`ifdef SERIAL_ALU_OVF_EN
            check({name, "_bp_hold"}, {bus.out_valid, bus.in_ready, 30'd0} ^
                  32'({bus.out_result, bus.out_cout, bus.out_zero, bus.out_err, bus.out_ovf} != snap),
                  {1'b1, 1'b0, 30'd0});
`else
            check({name, "_bp_hold"}, {bus.out_valid, bus.in_ready, 30'd0} ^
                  32'({bus.out_result, bus.out_cout, bus.out_zero, bus.out_err, 1'b0} != snap),
                  {1'b1, 1'b0, 30'd0});
`endif
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, "_post_hs"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    vec_t  vecs[9];
    resp_t r;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 3'b010, {32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}, 0};
        vecs[1] = '{32'h00000005, 32'h00000007, 3'b110, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
        vecs[2] = '{32'h00000003, 32'h00000009, 3'b111, {32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
        vecs[3] = '{32'h00000009, 32'h00000003, 3'b111, {32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}, 0};
        vecs[4] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, {32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0}, 10};
        vecs[5] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b001, {32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
        vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 3'b101, {32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0}, 0};
        vecs[7] = '{32'h00000001, 32'h00000002, 3'b010, {32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0}, 0};
        vecs[8] = '{32'h80000000, 32'h00000001, 3'b110, {32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1}, 0};

        // Reset state while reset is held
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_idle_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op);
            finish_op($sformatf("vec%0d", i), vecs[i].exp, vecs[i].hold);
        end

        // Reset during RUN at bit 12 discards the operation
        start_op(32'h00001234, 32'h00004321, 3'b010);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_in_ready", 32'(bus.in_ready), 32'd0);
        check_idle_outputs("midrun");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_release_in_ready", 32'(bus.in_ready), 32'd1);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) seen++;
            end
            check("midrun_no_response", 32'(seen), 32'd0);
        end
        r = model(32'd2, 32'd2, 3'b010);
        check("model_2p2", r.res, 32'd4);
        start_op(32'd2, 32'd2, 3'b010);
        finish_op("after_rst_add", r, 0);

        // Random operations against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  op;
            a  = $urandom;
            b  = (k % 4 == 0) ? a : $urandom;
            op = 3'($urandom_range(0, 7));
            r  = model(a, b, op);
            start_op(a, b, op);
            finish_op($sformatf("rand%0d_op%0b", k, op), r, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial ALU sequencer that drives a single one-bit ALU datapath. It processes a WIDTH-bit operation LSB-first, one bit per clock, feeding the carry back from each bit into the next. It accepts AND, OR, ADD, SUB and SLT operations through a valid/ready request port and returns result, carry-out and zero flag through a valid/ready response port. It is the area-minimal alternative to the parallel slice-array ALU with CLA.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal range is 2 or more.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- in_op  in  3  opcode: op[2] = binv; 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid & out_ready
- out_result  out  WIDTH  result
- out_cout  out  1  carry out of the MSB bit
- out_zero  out  1  out_result == 0
- out_err  out  1  in_op was not a legal opcode
- out_ovf  out  1  signed overflow; present only with SERIAL_ALU_OVF_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On accept, latch a, b and op into shift registers.
  - Initialise the carry register to op[2], so SUB and SLT get the +1 of the two's complement.
  - Set idx = 0 and go to RUN.
- RUN, each cycle, bit idx:
  - bcomp = b[idx] ^ op[2]
  - sum = a ^ bcomp ^ carry
  - carry_next = a&bcomp | a&carry | bcomp&carry
  - Bit result per opcode:
    - 000: a&bcomp
    - 001: a|bcomp
    - 010 and 110: sum
    - 111: 0 for every bit
  - Shift the bit result in from the MSB side and update carry.
  - When idx == WIDTH-1, go to DONE.
- SLT:
  - On the MSB cycle, capture set = sum.
  - out_result = {WIDTH-1 zeros, set}.
  - No overflow correction; this matches the datapath's set semantics.
- Illegal opcodes (011, 100, 101):
  - The block still runs WIDTH cycles.
  - out_result = 0, out_err = 1, out_cout = 0.
- DONE:
  - out_valid = 1 and all outputs are held stable.
  - On out_ready, go to IDLE.
- out_cout is the final carry register for ops 010, 110 and 111. It is 0 for 000 and 001.
- out_zero is computed from the final out_result.

## Timing
- Reset clears all of the following: in_ready = 0 while reset is asserted and 1 in the first cycle after release; out_valid = 0; out_result = 0; out_cout = 0; out_zero = 0; out_err = 0; out_ovf = 0; state = IDLE.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge.
- in_ready = 0 throughout RUN and DONE. There is no request overlap.
- The next request can be accepted in the cycle after the out_valid & out_ready handshake.
- Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- Backpressure: DONE is held indefinitely and outputs do not change.
- in_a, in_b and in_op are don't-care outside the accept cycle.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. The partial result is discarded, with no response.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - The out_ovf port exists.
  - For ADD and SUB, out_ovf = carry into the MSB ^ carry out of the MSB.
  - For all other opcodes, out_ovf = 0.
- SERIAL_ALU_OVF_EN undefined: the out_ovf port and the carry-into-MSB register are absent.

## Structure
- Shared package holds:
  - the opcode localparams: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111;
  - the state encoding for IDLE/RUN/DONE.
- One sub-module, serial_bit_slice:
  - combinational;
  - inputs: a, b, carry, op;
  - outputs: bit result, sum, carry_next.
- The FSM, shift registers, idx counter of width $clog2(WIDTH) and flags live in serial_alu_ctrl.

## Test plan
All cases use WIDTH=32.
- ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout=1, zero=1, out_valid exactly 32 clocks after accept; with OVF_EN, ovf=0.
- SUB 5 - 7 -> result 0xFFFFFFFE, cout=0, zero=0. SUB 0x80000000 - 1 with OVF_EN -> 0x7FFFFFFF, ovf=1.
- SLT 3,9 -> result 0x00000001. SLT 9,3 -> 0x00000000, zero=1. AND 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000. OR of the same operands -> 0xFFF0FFF0.
- Illegal op 3'b101 on any operands -> result 0, err=1. A following legal ADD clears err.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. Then pulse out_ready -> in_ready=1 the next cycle.
- Assert reset at RUN bit 12 -> all outputs at reset values, no out_valid. A new ADD 2+2 after release -> result 4.
